branch_resolve_unit: RTL and testbench

- Closes the loop on the branch history table predictor from the execute/memory side.
- Records every prediction made at decode in a small in-order queue. At resolution it compares the actual outcome with the queued prediction.
- Drives the predictor's update interface (branch_mem_sig, actual_branch_decision, update_branch_addr) and raises flush/redirect on a mispredict.
- Sits between the decode-stage predictor and the fetch PC mux.

---
 rtl/branch_resolve_unit_pkg.sv | 15 +
 rtl/branch_pred_queue.sv | 63 ++++++
 rtl/branch_resolve_unit.sv | 116 +++++++++++
 tb/tb_branch_resolve_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction queue.
package branch_resolve_unit_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int DEPTH_DEF  = 4;
   localparam int INSN_BYTES = 4;

   // One in-flight prediction as recorded at decode.
   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic                pred_taken;
      logic [XLEN_DEF-1:0] pred_target;
   } br_entry_t;

endpackage

// File: rtl/branch_pred_queue.sv
// In-order circular FIFO of outstanding branch predictions with push, pop and flush.
module branch_pred_queue
   import branch_resolve_unit_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter type entry_t = br_entry_t
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   input  logic   flush,
   output logic   full,
   output logic   empty,
   output entry_t head_data
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [PW:0]   count_q;
   entry_t        mem [DEPTH];
   logic          push_ok;
   logic          pop_ok;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign head_data = mem[head_q];

   // A full queue still accepts a push when the same edge pops a slot free.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= tail_q;
         count_q <= '0;
      end else begin
         if (push_ok) tail_q <= tail_q + PTR_ONE;
         if (pop_ok)  head_q <= head_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; occupancy is tracked by count_q, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[tail_q] <= push_data;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against actual outcomes, updates the predictor and redirects on mispredict.
// Optional saturating statistics counters are enabled with `define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int XLEN  = XLEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dec_valid,
   input  logic [XLEN-1:0] dec_pc,
   input  logic            dec_pred_taken,
   input  logic [XLEN-1:0] dec_pred_target,
   output logic            dec_ready,
   input  logic            res_valid,
   input  logic            res_taken,
   input  logic [XLEN-1:0] res_target,
   output logic            branch_mem_sig,
   output logic            actual_branch_decision,
   output logic [XLEN-1:0] update_branch_addr,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic            proto_err
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   // Same layout as br_entry_t, sized by this instance's XLEN.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            pred_taken;
      logic [XLEN-1:0] pred_target;
   } entry_t;

   entry_t enq_entry;
   entry_t head;
   logic   full;
   logic   empty;
   logic   do_res;
   logic   mis_cond;
   logic   flush;
   logic   do_push;

   assign enq_entry = '{pc: dec_pc, pred_taken: dec_pred_taken, pred_target: dec_pred_target};

   assign dec_ready = !full;
   assign do_res    = res_valid && !empty;
   assign mis_cond  = (head.pred_taken != res_taken) ||
                      (res_taken && (head.pred_target != res_target));
   assign flush     = do_res && mis_cond;
   // A push alongside a mispredict is a wrong-path branch and is discarded.
   assign do_push   = dec_valid && !flush && (!full || do_res);

   branch_pred_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (do_push),
      .push_data (enq_entry),
      .pop       (do_res),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .head_data (head)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_mem_sig         <= 1'b0;
         actual_branch_decision <= 1'b0;
         update_branch_addr     <= '0;
         mispredict             <= 1'b0;
         redirect_pc            <= '0;
         proto_err              <= 1'b0;
      end else begin
         branch_mem_sig <= do_res;
         mispredict     <= flush;
         if (do_res) begin
            actual_branch_decision <= res_taken;
            update_branch_addr     <= head.pc;
         end
         // Fall-through PC wraps modulo 2^XLEN.
         if (flush)
            redirect_pc <= res_taken ? res_target : head.pc + XLEN'(INSN_BYTES);
         if (res_valid && empty)
            proto_err <= 1'b1;
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_branches_q;
   logic [31:0] stat_mispredicts_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         if (do_res && (stat_branches_q != '1))
            stat_branches_q <= stat_branches_q + 32'd1;
         if (flush && (stat_mispredicts_q != '1))
            stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4, XLEN=32).
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic        dec_pred_taken;
   logic [31:0] dec_pred_target;
   logic        dec_ready;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        branch_mem_sig;
   logic        actual_branch_decision;
   logic [31:0] update_branch_addr;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        proto_err;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(4), .XLEN(32)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .dec_valid              (dec_valid),
      .dec_pc                 (dec_pc),
      .dec_pred_taken         (dec_pred_taken),
      .dec_pred_target        (dec_pred_target),
      .dec_ready              (dec_ready),
      .res_valid              (res_valid),
      .res_taken              (res_taken),
      .res_target             (res_target),
      .branch_mem_sig         (branch_mem_sig),
      .actual_branch_decision (actual_branch_decision),
      .update_branch_addr     (update_branch_addr),
      .mispredict             (mispredict),
      .redirect_pc            (redirect_pc),
      .proto_err              (proto_err)
`ifdef BRANCH_RESOLVE_STATS_EN
      ,
      .stat_branches          (stat_branches),
      .stat_mispredicts       (stat_mispredicts)
`endif
   );

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dec_valid = 1'b0; dec_pc = '0; dec_pred_taken = 1'b0; dec_pred_target = '0;
      res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
   endtask

   task automatic set_enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      dec_valid = 1'b1; dec_pc = pc; dec_pred_taken = pt; dec_pred_target = tgt;
   endtask

   task automatic set_res(input logic tk, input logic [31:0] tgt);
      res_valid = 1'b1; res_taken = tk; res_target = tgt;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL rst_bms: got %b want 0", branch_mem_sig); end
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", mispredict); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr: got %b want 0", proto_err); end
      n_checks++; if (update_branch_addr !== 32'h0) begin n_fail++; $display("FAIL rst_uba: got %h want 0", update_branch_addr); end
      n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_rpc: got %h want 0", redirect_pc); end
      n_checks++; if (actual_branch_decision !== 1'b0) begin n_fail++; $display("FAIL rst_abd: got %b want 0", actual_branch_decision); end
      step();
      reset = 1'b0;
      step(); step();
      n_checks++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", dec_ready); end
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL idle_bms: got %b want 0", branch_mem_sig); end
   endtask

   task automatic test_correct_prediction();
      set_enq(32'h100, 1'b1, 32'h140);
      step();
      idle_inputs();
      set_res(1'b1, 32'h140);
      step();
      idle_inputs();
      n_checks++; if (branch_mem_sig !== 1'b1) begin n_fail++; $display("FAIL corr_bms: got %b want 1", branch_mem_sig); end
      n_checks++; if (actual_branch_decision !== 1'b1) begin n_fail++; $display("FAIL corr_abd: got %b want 1", actual_branch_decision); end
      n_checks++; if (update_branch_addr !== 32'h100) begin n_fail++; $display("FAIL corr_uba: got %h want 00000100", update_branch_addr); end
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL corr_mis: got %b want 0", mispredict); end
      step();
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL corr_bms_pulse: got %b want 0", branch_mem_sig); end
      n_checks++; if (update_branch_addr !== 32'h100) begin n_fail++; $display("FAIL corr_uba_hold: got %h want 00000100", update_branch_addr); end
   endtask

   task automatic test_direction_mispredict();
      set_enq(32'h200, 1'b1, 32'h240);
      step();
      set_enq(32'h210, 1'b0, 32'h250);
      step();
      idle_inputs();
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL dir_mis: got %b want 1", mispredict); end
      n_checks++; if (redirect_pc !== 32'h204) begin n_fail++; $display("FAIL dir_rpc: got %h want 00000204", redirect_pc); end
      n_checks++; if (update_branch_addr !== 32'h200) begin n_fail++; $display("FAIL dir_uba: got %h want 00000200", update_branch_addr); end
      n_checks++; if (actual_branch_decision !== 1'b0) begin n_fail++; $display("FAIL dir_abd: got %b want 0", actual_branch_decision); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL dir_perr_pre: got %b want 0", proto_err); end
      // 0x210 was flushed, so this resolve finds the queue empty.
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL dir_mis_pulse: got %b want 0", mispredict); end
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL dir_empty_bms: got %b want 0", branch_mem_sig); end
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL dir_perr: got %b want 1", proto_err); end
      step();
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL dir_perr_sticky: got %b want 1", proto_err); end
   endtask

   task automatic test_flush_discards_enqueue();
      do_reset();
      set_enq(32'h300, 1'b1, 32'h340);
      step();
      set_enq(32'h310, 1'b0, 32'h350);
      set_res(1'b1, 32'h344);
      step();
      idle_inputs();
      n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL tgt_mis: got %b want 1", mispredict); end
      n_checks++; if (redirect_pc !== 32'h344) begin n_fail++; $display("FAIL tgt_rpc: got %h want 00000344", redirect_pc); end
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL flush_enq_bms: got %b want 0", branch_mem_sig); end
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL flush_enq_perr: got %b want 1", proto_err); end
   endtask

   task automatic test_wrap();
      do_reset();
      set_enq(32'hFFFF_FFFC, 1'b0, 32'h10);
      step();
      idle_inputs();
      set_res(1'b1, 32'h10);
      step();
      idle_inputs();
      n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL wrap_mis: got %b want 1", mispredict); end
      n_checks++; if (redirect_pc !== 32'h10) begin n_fail++; $display("FAIL wrap_rpc: got %h want 00000010", redirect_pc); end
      set_enq(32'hFFFF_FFFC, 1'b0, 32'h10);
      step();
      idle_inputs();
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL wrap_nt_mis: got %b want 0", mispredict); end
      n_checks++; if (branch_mem_sig !== 1'b1) begin n_fail++; $display("FAIL wrap_nt_bms: got %b want 1", branch_mem_sig); end
      n_checks++; if (redirect_pc !== 32'h10) begin n_fail++; $display("FAIL wrap_rpc_hold: got %h want 00000010", redirect_pc); end
      // Predicted taken, actually not taken: fall-through pc+4 wraps to zero.
      set_enq(32'hFFFF_FFFC, 1'b1, 32'h80);
      step();
      idle_inputs();
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL wrap4_mis: got %b want 1", mispredict); end
      n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap4_rpc: got %h want 00000000", redirect_pc); end
   endtask

   task automatic test_full_boundary();
      logic [31:0] exp_pc [5];
      exp_pc[0] = 32'h1000; exp_pc[1] = 32'h1010; exp_pc[2] = 32'h1020;
      exp_pc[3] = 32'h1030; exp_pc[4] = 32'h1050;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_enq(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h2000);
         step();
      end
      idle_inputs();
      n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", dec_ready); end
      set_enq(32'h1040, 1'b0, 32'h2000);
      step();
      set_enq(32'h1050, 1'b0, 32'h2000);
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (update_branch_addr !== 32'h1000) begin n_fail++; $display("FAIL full_pop_uba: got %h want 00001000", update_branch_addr); end
      n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL full_still_full: got %b want 0", dec_ready); end
      // Back-to-back resolves drain the rest; 0x1040 must be absent, 0x1050 present.
      for (int i = 1; i < 5; i++) begin
         set_res(1'b0, 32'h0);
         step();
         n_checks++; if (branch_mem_sig !== 1'b1 || update_branch_addr !== exp_pc[i]) begin
            n_fail++; $display("FAIL drain_%0d: got bms=%b uba=%h want bms=1 uba=%h", i, branch_mem_sig, update_branch_addr, exp_pc[i]);
         end
      end
      idle_inputs();
      n_checks++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b want 1", dec_ready); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL drain_perr: got %b want 0", proto_err); end
   endtask

   task automatic test_empty_no_bypass();
      set_enq(32'h400, 1'b1, 32'h440);
      set_res(1'b1, 32'h440);
      step();
      idle_inputs();
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL nobyp_bms: got %b want 0", branch_mem_sig); end
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL nobyp_perr: got %b want 1", proto_err); end
      set_res(1'b1, 32'h440);
      step();
      idle_inputs();
      n_checks++; if (branch_mem_sig !== 1'b1 || update_branch_addr !== 32'h400 || mispredict !== 1'b0) begin
         n_fail++; $display("FAIL nobyp_later: got bms=%b uba=%h mis=%b want bms=1 uba=00000400 mis=0", branch_mem_sig, update_branch_addr, mispredict);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         set_enq(32'h500 + 32'(i) * 32'h4, 1'b0, 32'h600);
         step();
      end
      idle_inputs();
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (branch_mem_sig !== 1'b1) begin n_fail++; $display("FAIL ar_pre_bms: got %b want 1", branch_mem_sig); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (branch_mem_sig !== 1'b0) begin n_fail++; $display("FAIL ar_bms: got %b want 0", branch_mem_sig); end
      n_checks++; if (update_branch_addr !== 32'h0) begin n_fail++; $display("FAIL ar_uba: got %h want 0", update_branch_addr); end
      n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL ar_rpc: got %h want 0", redirect_pc); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL ar_perr: got %b want 0", proto_err); end
      step();
      reset = 1'b0;
      step();
      set_res(1'b0, 32'h0);
      step();
      idle_inputs();
      n_checks++; if (branch_mem_sig !== 1'b0 || proto_err !== 1'b1) begin
         n_fail++; $display("FAIL ar_queue_empty: got bms=%b perr=%b want bms=0 perr=1", branch_mem_sig, proto_err);
      end
   endtask

`ifdef BRANCH_RESOLVE_STATS_EN
   task automatic test_stats();
      do_reset();
      set_enq(32'h700, 1'b0, 32'h0); step();
      set_enq(32'h704, 1'b0, 32'h0); step();
      idle_inputs();
      set_res(1'b0, 32'h0); step();
      set_res(1'b0, 32'h0); step();
      idle_inputs();
      set_enq(32'h708, 1'b1, 32'h800); step();
      idle_inputs();
      set_res(1'b0, 32'h0); step();
      idle_inputs();
      n_checks++; if (stat_branches !== 32'd3) begin n_fail++; $display("FAIL stat_br: got %0d want 3", stat_branches); end
      n_checks++; if (stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL stat_mis: got %0d want 1", stat_mispredicts); end
      force dut.stat_branches_q = 32'hFFFF_FFFE;
      force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat_branches_q;
      release dut.stat_mispredicts_q;
      for (int i = 0; i < 2; i++) begin
         set_enq(32'h900, 1'b1, 32'h940); step();
         idle_inputs();
         set_res(1'b0, 32'h0); step();
         idle_inputs();
      end
      n_checks++; if (stat_branches !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stat_br_sat: got %h want ffffffff", stat_branches); end
      n_checks++; if (stat_mispredicts !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stat_mis_sat: got %h want ffffffff", stat_mispredicts); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      idle_inputs();
      #3;
      test_reset();
      test_correct_prediction();
      test_direction_mispredict();
      test_flush_discards_enqueue();
      test_wrap();
      test_full_boundary();
      test_empty_no_bypass();
      test_async_reset();
`ifdef BRANCH_RESOLVE_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
